// File: rtl/mem_access_unit.sv
// Load/store unit between the execute stage and a synchronous-read data RAM.
// Optional feature: define MISALIGN_TRAP_EN to reject misaligned half/word accesses.
module mem_access_unit #(
  parameter int MEM_AW = 14
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  output logic              busy,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_wea,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout,
  output logic              misalign
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    MERGE = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                we_q;
  logic [1:0]          size_q;
  logic                sext_q;
  logic [MEM_AW+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic                pend_q, pend_d;
  logic [1:0]          pend_size_q;
  logic                pend_sext_q;
  logic [1:0]          pend_lane_q;
  logic [31:0]         load_data_q;
  logic                load_valid_q;
  logic                misalign_q;
  logic                misalign_s;
  logic                accept_s;
  logic                unused_addr_s;

  function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] sz,
                                               input logic sx, input logic [1:0] ln);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (ln)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = ln[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = {{24{sx & b[7]}}, b};
      2'b01:   r = {{16{sx & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [1:0] sz, input logic [1:0] ln);
    logic [31:0] m;
    m = old;
    case (sz)
      2'b00: begin
        case (ln)
          2'd0:    m[7:0]   = wd[7:0];
          2'd1:    m[15:8]  = wd[7:0];
          2'd2:    m[23:16] = wd[7:0];
          default: m[31:24] = wd[7:0];
        endcase
      end
      2'b01: begin
        if (ln[1]) m[31:16] = wd[15:0];
        else       m[15:0]  = wd[15:0];
      end
      default: m = wd;
    endcase
    return m;
  endfunction

`ifdef MISALIGN_TRAP_EN
  assign misalign_s = ((size == 2'b01) && address[0]) ||
                      (size[1] && (address[1:0] != 2'b00));
`else
  assign misalign_s = 1'b0;
`endif

  assign accept_s      = (state_q == IDLE) && req && !misalign_s;
  assign unused_addr_s = ^address[31:MEM_AW+2];

  // Next-state decode; a load marks its RAM word for capture one cycle after READ.
  always_comb begin
    state_d = state_q;
    pend_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (we && size[1]) state_d = WRITE;
          else               state_d = READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        pend_d = !we_q;
        if (we_q) state_d = MERGE;
        else      state_d = IDLE;
      end
      MERGE:   state_d = IDLE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      sext_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'h0000_0000;
      pend_q       <= 1'b0;
      pend_size_q  <= 2'b00;
      pend_sext_q  <= 1'b0;
      pend_lane_q  <= 2'b00;
      load_data_q  <= 32'h0000_0000;
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      load_valid_q <= pend_q;
      misalign_q   <= (state_q == IDLE) && req && misalign_s;
      if (accept_s) begin
        we_q    <= we;
        size_q  <= size;
        sext_q  <= sign_ext;
        addr_q  <= address[MEM_AW+1:0];
        wdata_q <= write_data;
      end
      // Snapshot the load shape so a back-to-back request can reuse the holding registers.
      if (pend_d) begin
        pend_size_q <= size_q;
        pend_sext_q <= sext_q;
        pend_lane_q <= addr_q[1:0];
      end
      if (pend_q) begin
        load_data_q <= lane_extract(mem_dout, pend_size_q, pend_sext_q, pend_lane_q);
      end
    end
  end

  // RAM write port decode; the merge path uses the word read during READ.
  always_comb begin
    mem_din = 32'h0000_0000;
    case (state_q)
      WRITE:   mem_din = wdata_q;
      MERGE:   mem_din = lane_merge(mem_dout, wdata_q, size_q, addr_q[1:0]);
      default: mem_din = 32'h0000_0000;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign mem_wea    = (state_q == WRITE) || (state_q == MERGE);
  assign mem_addr   = addr_q[MEM_AW+1:2];
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign misalign   = misalign_q;

endmodule
